// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg: shared types for the keypad digit-entry block.
// Holds the debounce FSM state enum, the BCD digit type and MAX_DIGIT.
package digit_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HELD,
        ST_RELEASE
    } deb_state_e;

    typedef logic [3:0] digit_t;

    localparam digit_t MAX_DIGIT = 4'd9;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus press/release debounce FSM.
// Ports: i_clk, i_rst (sync, active high), i_key_digit, i_key_valid in;
//        o_accept (one-cycle pulse per debounced press), o_accept_digit out.
module key_debounce
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  digit_t i_key_digit,
    input  logic   i_key_valid,
    output logic   o_accept,
    output digit_t o_accept_digit
);

    localparam logic [7:0] DEB = 8'(DEBOUNCE);

    logic       r_s1_v;
    logic       r_s2_v;
    digit_t     r_s1_d;
    digit_t     r_s2_d;
    deb_state_e r_state;
    logic [7:0] r_cnt;
    digit_t     r_digit;
    logic       r_accept;
    logic [7:0] w_cnt_inc;

    assign w_cnt_inc      = r_cnt + 8'd1;
    assign o_accept       = r_accept;
    assign o_accept_digit = r_digit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_s1_d   <= '0;
            r_s2_d   <= '0;
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_digit  <= '0;
            r_accept <= 1'b0;
        end else begin
            r_s1_v   <= (i_key_valid == 1'b1);
            r_s2_v   <= r_s1_v;
            r_s1_d   <= i_key_digit;
            r_s2_d   <= r_s1_d;
            r_accept <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (r_s2_v && r_s2_d <= MAX_DIGIT) begin
                        r_state <= ST_PRESS;
                        r_digit <= r_s2_d;
                        r_cnt   <= 8'd1;
                    end
                end
                ST_PRESS: begin
                    // an out-of-range code mid-press counts as no key
                    if (!r_s2_v || r_s2_d > MAX_DIGIT) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_s2_d != r_digit) begin
                        r_digit <= r_s2_d;
                        r_cnt   <= 8'd1;
                    end else if (w_cnt_inc == DEB) begin
                        r_state  <= ST_HELD;
                        r_cnt    <= w_cnt_inc;
                        r_accept <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!r_s2_v) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= 8'd1;
                    end
                end
                ST_RELEASE: begin
                    // a bounce back to pressed re-holds without a new accept
                    if (r_s2_v) begin
                        r_state <= ST_HELD;
                    end else if (w_cnt_inc == DEB) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/digit_entry.sv
// digit_entry: debounced keypad digit entry with a BCD shift buffer and a
// committed-value register handed off via value_valid/value_ready.
// Ports: i_clk, i_rst, i_key_digit, i_key_valid, i_clear, i_enter,
//        i_value_ready in; o_digits, o_count, o_key_strobe, o_value,
//        o_value_valid out.
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE = 16,
    parameter int DIGITS   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_key_digit,
    input  logic                  i_key_valid,
    input  logic                  i_clear,
    input  logic                  i_enter,
    input  logic                  i_value_ready,
    output logic [4*DIGITS-1:0]   o_digits,
    output logic [3:0]            o_count,
    output logic                  o_key_strobe,
    output logic [4*DIGITS-1:0]   o_value,
    output logic                  o_value_valid
);

    localparam logic [3:0] FULL = 4'(DIGITS);

    logic [4*DIGITS-1:0] r_digits;
    logic [3:0]          r_count;
    logic                r_strobe;
    logic [4*DIGITS-1:0] r_value;
    logic                r_value_valid;

    logic                w_accept;
    digit_t              w_accept_digit;
    logic                w_commit;
    logic [4*DIGITS-1:0] w_single;
    logic [4*DIGITS-1:0] w_shift;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_deb (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_key_digit    (i_key_digit),
        .i_key_valid    (i_key_valid),
        .o_accept       (w_accept),
        .o_accept_digit (w_accept_digit)
    );

    assign w_commit = i_enter && (r_count != 4'd0) && !r_value_valid;
    assign w_single = (4*DIGITS)'(w_accept_digit);
    assign w_shift  = (r_digits << 4) | w_single;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digits      <= '0;
            r_count       <= '0;
            r_strobe      <= 1'b0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (r_value_valid && i_value_ready) begin
                r_value_valid <= 1'b0;
            end
            if (i_clear) begin
                r_digits <= '0;
                r_count  <= '0;
            end else if (w_commit) begin
                // commit takes the pre-accept buffer; a coincident key
                // starts the freshly emptied buffer
                r_value       <= r_digits;
                r_value_valid <= 1'b1;
                if (w_accept) begin
                    r_digits <= w_single;
                    r_count  <= 4'd1;
                    r_strobe <= 1'b1;
                end else begin
                    r_digits <= '0;
                    r_count  <= '0;
                end
            end else if (w_accept && r_count < FULL) begin
                r_digits <= w_shift;
                r_count  <= r_count + 4'd1;
                r_strobe <= 1'b1;
            end
        end
    end

    assign o_digits      = r_digits;
    assign o_count       = r_count;
    assign o_key_strobe  = r_strobe;
    assign o_value       = r_value;
    assign o_value_valid = r_value_valid;

endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry: directed and random stimulus for digit_entry, checked
// every cycle against a behavioural model of the keypad entry rules.
module tb_digit_entry;

    localparam int DEB = 4;
    localparam int ND  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_digit = '0;
    logic        key_valid = 1'b0;
    logic        clear = 1'b0;
    logic        enter = 1'b0;
    logic        value_ready = 1'b0;
    logic [15:0] o_digits;
    logic [3:0]  o_count;
    logic        o_key_strobe;
    logic [15:0] o_value;
    logic        o_value_valid;

    always #5 clk = ~clk;

    digit_entry #(
        .DEBOUNCE (DEB),
        .DIGITS   (ND)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_digit   (key_digit),
        .i_key_valid   (key_valid),
        .i_clear       (clear),
        .i_enter       (enter),
        .i_value_ready (value_ready),
        .o_digits      (o_digits),
        .o_count       (o_count),
        .o_key_strobe  (o_key_strobe),
        .o_value       (o_value),
        .o_value_valid (o_value_valid)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_strobe = 0;
    int last_strobe = 0;

    // model: buffer as a list of digits, most recent first
    int          q[$];
    logic [15:0] e_value = '0;
    bit          e_valid = 0;
    bit          e_strobe = 0;
    bit          s1v = 0;
    bit          s2v = 0;
    int          s1d = 0;
    int          s2d = 0;
    bit          acc = 0;
    int          accd = 0;
    bit          armed = 1;
    int          run = 0;
    int          run_d = 0;
    int          low = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] pack();
        logic [15:0] r = '0;
        foreach (q[i]) r |= 16'(q[i]) << (4 * i);
        return r;
    endfunction

    task automatic model_edge();
        bit was_valid;
        bit good;
        if (rst) begin
            q.delete();
            e_value = '0; e_valid = 0; e_strobe = 0;
            s1v = 0; s2v = 0; s1d = 0; s2d = 0;
            acc = 0; armed = 1; run = 0; low = 0;
            return;
        end
        // buffer acts on the key accepted at the previous edge
        e_strobe = 0;
        was_valid = e_valid;
        if (was_valid && value_ready) e_valid = 0;
        if (!clear && enter && q.size() > 0 && !was_valid) begin
            e_value = pack();
            e_valid = 1;
            q.delete();
            if (acc) begin
                q.push_front(accd);
                e_strobe = 1;
            end
        end else if (clear) begin
            q.delete();
        end else if (acc && q.size() < ND) begin
            q.push_front(accd);
            e_strobe = 1;
        end
        // debounce on the synchronized sample
        acc = 0;
        good = s2v && (s2d <= 9);
        if (armed) begin
            if (!good) begin
                run = 0;
            end else if (run > 0 && s2d == run_d) begin
                run++;
            end else begin
                run = 1;
                run_d = s2d;
            end
            if (run == DEB) begin
                acc = 1; accd = run_d;
                armed = 0; low = 0; run = 0;
            end
        end else begin
            low = s2v ? 0 : low + 1;
            if (low == DEB) begin
                armed = 1; low = 0; run = 0;
            end
        end
        s2v = s1v; s2d = s1d;
        s1v = key_valid; s1d = key_digit;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        if (o_key_strobe) begin
            n_strobe++;
            last_strobe = cyc;
        end
        check("digits", o_digits, pack());
        check("count", o_count, q.size());
        check("strobe", o_key_strobe, e_strobe);
        check("value", o_value, e_value);
        check("valid", o_value_valid, e_valid);
    endtask

    task automatic do_reset();
        rst = 1; key_valid = 0; key_digit = 0;
        clear = 0; enter = 0; value_ready = 0;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic press(int d, int hold);
        key_digit = 4'(d);
        key_valid = 1;
        repeat (hold) tick();
        key_valid = 0;
        repeat (DEB + 4) tick();
    endtask

    initial begin
        int t0;
        int s0;
        do_reset();
        check("rst_digits", o_digits, 16'h0);
        check("rst_valid", o_value_valid, 1'b0);

        // single press: latency and one strobe
        s0 = n_strobe;
        t0 = cyc + 1;
        press(7, 20);
        check("lat7", last_strobe - t0, DEB + 2);
        check("n7", n_strobe - s0, 1);
        check("d7", o_digits, 16'h0007);
        check("c7", o_count, 1);

        // fill and overflow
        do_reset();
        for (int k = 1; k <= 4; k++) press(k, 8);
        check("d1234", o_digits, 16'h1234);
        check("c4", o_count, 4);
        s0 = n_strobe;
        press(5, 8);
        check("nfull", n_strobe - s0, 0);
        check("dfull", o_digits, 16'h1234);

        // glitch, then digit change mid-window
        do_reset();
        s0 = n_strobe;
        key_digit = 2; key_valid = 1;
        repeat (3) tick();
        key_valid = 0;
        repeat (DEB + 4) tick();
        check("nglitch", n_strobe - s0, 0);
        key_digit = 3; key_valid = 1;
        repeat (2) tick();
        press(5, 10);
        check("nchg", n_strobe - s0, 1);
        check("dchg", o_digits, 16'h0005);

        // invalid code from idle is ignored
        s0 = n_strobe;
        press(12, 10);
        check("nbad", n_strobe - s0, 0);

        // commit with back-pressure
        do_reset();
        press(4, 8);
        press(2, 8);
        enter = 1;
        repeat (5) tick();
        enter = 0;
        check("v42", o_value, 16'h0042);
        check("vv42", o_value_valid, 1);
        check("d0", o_digits, 16'h0);
        value_ready = 1;
        tick();
        value_ready = 0;
        check("vv0", o_value_valid, 0);
        check("vhold", o_value, 16'h0042);

        // clear beats accept; reset mid-press
        do_reset();
        press(3, 8);
        s0 = n_strobe;
        clear = 1;
        press(6, 10);
        clear = 0;
        check("nclr", n_strobe - s0, 0);
        check("dclr", o_digits, 16'h0);
        check("cclr", o_count, 0);
        key_digit = 8; key_valid = 1;
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        check("nrst", n_strobe - s0, 0);
        check("drst", o_digits, 16'h0);
        repeat (10) tick();
        key_valid = 0;
        repeat (DEB + 4) tick();
        check("nrst2", n_strobe - s0, 1);
        check("drst2", o_digits, 16'h0008);

        // accept coincident with commit
        do_reset();
        press(1, 8);
        press(2, 8);
        key_digit = 9; key_valid = 1;
        t0 = cyc + 1;
        repeat (6) tick();
        enter = 1;
        tick();
        enter = 0;
        check("coin_at", cyc, t0 + DEB + 2);
        check("v12", o_value, 16'h0012);
        check("d9", o_digits, 16'h0009);
        check("c1", o_count, 1);
        repeat (4) tick();
        key_valid = 0;
        repeat (DEB + 4) tick();

        // random segments
        for (int s = 0; s < 300; s++) begin
            int len;
            key_valid = 1'($urandom_range(0, 1));
            key_digit = 4'($urandom_range(0, 9));
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                enter = ($urandom_range(0, 7) == 0);
                clear = ($urandom_range(0, 15) == 0);
                value_ready = ($urandom_range(0, 2) == 0);
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 Parameter DEBOUNCE, default 16: consecutive stable samples required to accept a press or a release (legal range 2..255).
REQ-002 Parameter DIGITS, default 4: depth of the BCD entry buffer (legal range 1..8).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_digit  input  4  digit code from the upstream 10-to-4 key encoder; 0..9 are valid.
REQ-006 key_valid  input  1  encoder "any key pressed" flag; any value other than 1 is treated as 0.
REQ-007 clear  input  1  level; empties the buffer.
REQ-008 enter  input  1  level; commits the buffer to the output register.
REQ-009 value_ready  input  1  consumer accepts the committed value.
REQ-010 digits  output  4*DIGITS  live buffer; nibble 0 holds the most recent digit.
REQ-011 count  output  4  number of digits held, 0..DIGITS.
REQ-012 key_strobe  output  1  one-cycle pulse when a key is shifted into the buffer.
REQ-013 value  output  4*DIGITS  committed value, stable while value_valid=1.
REQ-014 value_valid  output  1  committed value pending.

Function
REQ-015 key_digit and key_valid SHALL pass through a 2-flop synchronizer before use.
REQ-016 The debounce FSM SHALL have states IDLE, PRESS, HELD and RELEASE, with an 8-bit stability counter.
REQ-017 IDLE: synced key_valid=1 with digit 0..9 -> PRESS, capture the digit, counter=1; a digit >9 SHALL leave the FSM in IDLE.
REQ-018 PRESS: synced key_valid=0 -> IDLE; digit differs from captured -> recapture, counter=1; otherwise counter+1; counter reaching DEBOUNCE -> HELD with an accept event.
REQ-019 HELD: synced key_valid=0 -> RELEASE, counter=1; holding a key SHALL never produce a second accept.
REQ-020 RELEASE: synced key_valid=1 -> HELD; otherwise counter+1; counter reaching DEBOUNCE -> IDLE.
REQ-021 Accept event with count<DIGITS: shift digits left by one nibble, insert the digit at nibble 0, count+1, key_strobe=1 in that same cycle.
REQ-022 Accept event with count=DIGITS: the buffer SHALL be unchanged and key_strobe SHALL stay 0.
REQ-023 Latency: key_strobe SHALL assert exactly DEBOUNCE+2 cycles after the first clock edge at which raw key_valid=1 with a stable digit.
REQ-024 Commit condition: enter=1, count>0 and value_valid=0; then next cycle value=digits, value_valid=1, digits=0, count=0.
REQ-025 enter while value_valid=1 or count=0 SHALL be ignored.
REQ-026 value_valid SHALL clear in the cycle after value_valid=1 and value_ready=1; value SHALL hold its contents until the next commit.
REQ-027 clear=1 SHALL zero digits and count and suppress key_strobe; clear wins over a simultaneous accept, and also over enter (no commit).
REQ-028 An accept simultaneous with a commit SHALL commit the pre-accept buffer, and the new digit SHALL become the sole digit (count=1) of the emptied buffer.
REQ-029 clear SHALL NOT affect value or value_valid.

Reset
REQ-030 rst=1 SHALL force: FSM to IDLE, counter=0, synchronizers=0, digits=0, count=0, key_strobe=0, value=0, value_valid=0.
REQ-031 rst asserted mid-debounce or mid-handshake SHALL abort without an accept; a key still held after reset SHALL be accepted once after a full DEBOUNCE window.

Structure
REQ-032 Package digit_entry_pkg SHALL hold the FSM state enum, the 4-bit digit type and the MAX_DIGIT=9 constant.
REQ-033 The synchronizer and debounce FSM SHALL be a sub-module key_debounce producing accept and accept_digit; the buffer and commit logic stay in digit_entry.

Verification (DEBOUNCE=4, DIGITS=4)
REQ-034 Press 7 held for 20 cycles, then release -> key_strobe exactly once, 6 cycles after the first high sample; digits=16'h0007, count=1.
REQ-035 Enter 1,2,3,4,5 -> after the 4th key digits=16'h1234, count=4; the 5th key gives no key_strobe and no change.
REQ-036 key_valid glitches high for 3 cycles, and a press whose digit changes 3->5 mid-window -> no strobe for the glitch; one strobe for digit 5.
REQ-037 Buffer 16'h0042, pulse enter with value_ready=0 for 5 cycles -> value=16'h0042, value_valid held high, digits=0; value_ready=1 -> value_valid=0 next cycle.
REQ-038 clear and an accept in the same cycle -> digits=0, count=0, no key_strobe; rst during PRESS -> no strobe, all outputs 0.
REQ-039 Accept of 9 in the same cycle as enter with buffer 16'h0012 -> value=16'h0012, digits=16'h0009, count=1.
